// File: rtl/adc_sample_packer.sv
// ADC sample packer: buffers the converter's 128-bit word stream in a FIFO and serialises each word into two 64-bit AXIS beats.
// Defining ADC_TEST_PATTERN_EN adds a test_mode input and an internal incrementing-pattern source.
module adc_sample_packer #(
    parameter int          DEPTH        = 16,
    parameter bit          LOW_FIRST    = 1'b1,
    parameter logic [63:0] PATTERN_SEED = 64'h007C_B66B_A55A_0000
) (
    input  logic                   s01_axis_aclk,
    input  logic                   m00_axis_aresetn,
    input  logic                   enable,
    input  logic                   clear_status,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    input  logic [127:0]           s00_axis_tdata,
    input  logic                   s00_axis_tvalid,
    output logic [63:0]            m00_axis_tdata,
    output logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tready,
    output logic                   overflow,
    output logic [31:0]            drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of two in 4..256");
    end

    // Reset input is active-high; assertion is immediate, release is retimed to the clock.
    logic [1:0] rst_pipe;
    logic       rst;

    always_ff @(posedge s01_axis_aclk or posedge m00_axis_aresetn) begin
        if (m00_axis_aresetn) rst_pipe <= 2'b11;
        else                  rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst = rst_pipe[1];

    logic         wr_req;
    logic [127:0] wr_data;

`ifdef ADC_TEST_PATTERN_EN
    logic        pat_phase;
    logic [63:0] pat_p;

    always_ff @(posedge s01_axis_aclk or posedge rst) begin
        if (rst) begin
            pat_phase <= 1'b0;
            pat_p     <= PATTERN_SEED;
        end else begin
            pat_phase <= test_mode ? ~pat_phase : 1'b0;
            if (test_mode && pat_phase && enable) pat_p <= pat_p + 64'd2;
        end
    end

    always_comb begin
        wr_req  = s00_axis_tvalid && enable;
        wr_data = s00_axis_tdata;
        if (test_mode) begin
            wr_req  = pat_phase && enable;
            wr_data = LOW_FIRST ? {pat_p + 64'd1, pat_p} : {pat_p, pat_p + 64'd1};
        end
    end
`else
    assign wr_req  = s00_axis_tvalid && enable;
    assign wr_data = s00_axis_tdata;
`endif

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_wr;
    logic          drop;
    logic          pop;
    logic          nempty_q;
    logic [127:0]  head;

    // Full is taken from the registered level, so a pop in the same cycle does not make room.
    assign full  = (fifo_level == FULL);
    assign do_wr = wr_req && !full;
    assign drop  = wr_req && full;
    assign head  = mem[rd_ptr];

    always_ff @(posedge s01_axis_aclk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge s01_axis_aclk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            nempty_q   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            nempty_q <= (fifo_level != '0);
            case ({do_wr, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A clear in the same cycle as a drop wins; that drop is not counted.
    always_ff @(posedge s01_axis_aclk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
        end
    end

    function automatic logic [63:0] first_half(input logic [127:0] w);
        return LOW_FIRST ? w[63:0] : w[127:64];
    endfunction

    function automatic logic [63:0] second_half(input logic [127:0] w);
        return LOW_FIRST ? w[127:64] : w[63:0];
    endfunction

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t      state;
    logic [63:0] hold;

    // IDLE waits on the registered not-empty flag: fixed two-cycle write-to-first-beat latency.
    assign pop = ((state == IDLE) && nempty_q) ||
                 ((state == BEAT1) && m00_axis_tready && (fifo_level != '0));

    always_ff @(posedge s01_axis_aclk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            hold            <= '0;
            m00_axis_tdata  <= '0;
            m00_axis_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (nempty_q) begin
                        hold            <= second_half(head);
                        m00_axis_tdata  <= first_half(head);
                        m00_axis_tvalid <= 1'b1;
                        state           <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (m00_axis_tready) begin
                        m00_axis_tdata <= hold;
                        state          <= BEAT1;
                    end
                end
                BEAT1: begin
                    if (m00_axis_tready) begin
                        if (fifo_level != '0) begin
                            hold           <= second_half(head);
                            m00_axis_tdata <= first_half(head);
                            state          <= BEAT0;
                        end else begin
                            m00_axis_tvalid <= 1'b0;
                            state           <= IDLE;
                        end
                    end
                end
                default: begin
                    m00_axis_tvalid <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule
